tracker_sequencer: RTL and testbench
====================================

TRACKER_SEQUENCER -- requirements
Module: tracker_sequencer

Interface
REQ-001 Parameter THRESH, default 64: minimum |LDR difference| that triggers a move.
REQ-002 Parameter MOVE_CYCLES, default 1000: CLK cycles per move step.
REQ-003 Parameter SETTLE_CYCLES, default 500: CLK cycles of wait after a move.
REQ-004 Parameter PERIOD_CYCLES, default 2000: CLK cycles idle between tracking rounds.
REQ-005 Parameter POS_MIN / POS_MAX, default 500 / 2500: servo pulse-width limits in us.
REQ-006 CLK  in  1  system clock, 100 MHz.
REQ-007 RST_N  in  1  reset; one clock, synchronous, active-low.
REQ-008 MODE_MANUAL  in  1  1 = manual control from buttons.
REQ-009 BTN_L, BTN_R, BTN_U, BTN_D  in  1 each  manual jog buttons.
REQ-010 LDR_VALID  in  1  one-cycle strobe; LDR_L/R/T/B are valid in that cycle.
REQ-011 LDR_L, LDR_R, LDR_T, LDR_B  in  12 each  unsigned light levels.
REQ-012 POS_H, POS_V  in  32 each  current pulse width from each servo_driver.
REQ-013 H_BTN0, H_BTN1, V_BTN0, V_BTN1  out  1 each  servo_driver direction inputs; BTN0 = cw, BTN1 = ccw.
REQ-014 ES_H, ES_V, MC  out  1 each  sweep-enable per axis; manual-control flag.
REQ-015 BUSY  out  1  high in every state except IDLE.
REQ-016 STATE  out  3  current FSM state code.

Function
REQ-017 All outputs SHALL be registered; no combinational input-to-output path.
REQ-018 States and encodings: IDLE=0, SAMPLE=1, ALIGN_H=2, SETTLE_H=3, ALIGN_V=4, SETTLE_V=5, MANUAL=6.
REQ-019 IDLE: count PERIOD_CYCLES, then go to SAMPLE; the counter restarts on every IDLE entry.
REQ-020 SAMPLE: wait indefinitely for LDR_VALID.
REQ-021 SAMPLE, on LDR_VALID: latch the four LDR values, then go to ALIGN_H in the next cycle.
REQ-022 Differences: dh = LDR_L - LDR_R and dv = LDR_T - LDR_B, each a 13-bit signed value; no overflow is possible.
REQ-023 ALIGN_H decision, made on the entry cycle:
- |dh| <= THRESH: skip to ALIGN_V.
- dh > 0: ccw (H_BTN1=1).
- dh < 0: cw (H_BTN0=1).
REQ-024 ALIGN_H limit gate: a cw move with POS_H >= POS_MAX, or a ccw move with POS_H <= POS_MIN, SHALL be dropped and the FSM skips to ALIGN_V.
REQ-025 ALIGN_H drive: hold the chosen BTN and ES_H=1 for MOVE_CYCLES cycles, then go to SETTLE_H.
REQ-026 ALIGN_H early abort: if POS_H crosses the active limit mid-move, drop the BTN on the next cycle and go to SETTLE_H.
REQ-027 SETTLE_H: all BTN outputs 0; wait SETTLE_CYCLES, then go to ALIGN_V.
REQ-028 ALIGN_V / SETTLE_V: identical to REQ-023..027 using dv, POS_V, V_BTN0/1 and ES_V (dv > 0 means ccw); SETTLE_V, or a skipped ALIGN_V, returns to IDLE.
REQ-029 BTN0 and BTN1 of the same axis SHALL never be 1 in the same cycle.
REQ-030 At most one axis moves at a time.
REQ-031 MODE_MANUAL=1 in any state: enter MANUAL on the next cycle, abort any move and clear the moving BTN.
REQ-032 MANUAL: MC=1 and ES_H=ES_V=0.
REQ-033 MANUAL horizontal: BTN_R drives H_BTN0 and BTN_L drives H_BTN1, one cycle registered.
REQ-034 MANUAL vertical: BTN_U drives V_BTN0 and BTN_D drives V_BTN1, one cycle registered.
REQ-035 MANUAL: both buttons of one axis pressed gives stop on that axis; the REQ-024 limit gating applies.
REQ-036 MODE_MANUAL=0 while in MANUAL: go to IDLE with MC=0 and all BTN outputs 0.
REQ-037 An LDR_VALID strobe outside SAMPLE SHALL be ignored.

Reset
REQ-038 While RST_N=0 at a CLK edge: STATE=IDLE; all counters 0; latched LDR values 0; every output 0 (BUSY=0, MC=0, all BTN/ES=0).
REQ-039 Reset asserted mid-move SHALL clear the BTN outputs on the same edge.
REQ-040 After RST_N returns to 1, the first SAMPLE entry occurs after PERIOD_CYCLES cycles.

Structure
REQ-041 A shared package SHALL hold:
- the state encodings;
- direction codes STOP=00, CW=01, CCW=10, matching servo_driver;
- the POS_MIN/POS_MAX defaults.
REQ-042 One sub-module, axis_mover, SHALL implement the per-axis decision, limit gate and move/settle counter; it is instantiated twice and sequenced by the top FSM.

Verification
REQ-043 LDR_L=2000, LDR_R=1000, POS_H=1500 -> H_BTN1=1 and ES_H=1 for exactly 1000 cycles, then 500 settle cycles, then vertical evaluated.
REQ-044 LDR_L=1030, LDR_R=1000, LDR_T=LDR_B=800 -> no BTN ever asserted; return to IDLE two cycles after the sample.
REQ-045 LDR_R > LDR_L by 500 with POS_H=2500 -> cw move dropped, H_BTN0 stays 0.
REQ-046 LDR_R > LDR_L by 500 with POS_H=2400 rising to 2500 at move cycle 300 -> H_BTN0 drops one cycle later.
REQ-047 MODE_MANUAL=1 at move cycle 200 -> BTN cleared and STATE=6 next cycle; BTN_U=BTN_D=1 -> V_BTN0=V_BTN1=0.
REQ-048 RST_N=0 for one cycle mid ALIGN_V -> all outputs 0 and STATE=0 next cycle; SAMPLE re-entered after 2000 cycles.

Source files
------------

// File: rtl/tracker_sequencer_pkg.sv
// Shared definitions for the solar tracker sequencer: FSM state codes,
// servo_driver direction codes and servo pulse-width limits.
package tracker_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SAMPLE   = 3'd1,
    ST_ALIGN_H  = 3'd2,
    ST_SETTLE_H = 3'd3,
    ST_ALIGN_V  = 3'd4,
    ST_SETTLE_V = 3'd5,
    ST_MANUAL   = 3'd6
  } state_t;

  // Bit 0 maps to BTN0 (cw) and bit 1 to BTN1 (ccw) of the servo_driver.
  typedef enum logic [1:0] {
    DIR_STOP = 2'b00,
    DIR_CW   = 2'b01,
    DIR_CCW  = 2'b10
  } dir_t;

  localparam int POS_MIN_DEF = 500;
  localparam int POS_MAX_DEF = 2500;

  // Drops a direction that would push the servo further past its limit.
  function automatic dir_t limit_gate(input dir_t dir, input logic [31:0] pos,
                                      input logic [31:0] pos_min,
                                      input logic [31:0] pos_max);
    dir_t d;
    d = dir;
    if ((dir == DIR_CW) && (pos >= pos_max)) d = DIR_STOP;
    if ((dir == DIR_CCW) && (pos <= pos_min)) d = DIR_STOP;
    return d;
  endfunction

endpackage

// File: rtl/tracker_sequencer_axis_mover.sv
// Per-axis move engine: direction decision from the LDR difference, limit
// gating, move/settle counting and the registered BTN/ES outputs of one axis.
module axis_mover
  import tracker_sequencer_pkg::*;
#(
  parameter int THRESH        = 64,
  parameter int MOVE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 500,
  parameter int POS_MIN       = POS_MIN_DEF,
  parameter int POS_MAX       = POS_MAX_DEF
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_align,
  input  logic               i_settle,
  input  logic               i_manual,
  input  logic               i_abort,
  input  logic signed [12:0] i_diff,
  input  logic [31:0]        i_pos,
  input  logic               i_man_btn0,
  input  logic               i_man_btn1,
  output logic               o_btn0,
  output logic               o_btn1,
  output logic               o_es,
  output logic               o_skip,
  output logic               o_move_done,
  output logic               o_settle_done
);

  logic               r_active;
  dir_t               r_dir;
  logic [31:0]        r_cnt;
  logic signed [12:0] w_mag;
  dir_t               w_want;
  dir_t               w_dec;
  dir_t               w_man_want;
  dir_t               w_man_dir;
  logic               w_lim_hit;

  assign w_mag = (i_diff < 13'sd0) ? -i_diff : i_diff;

  always_comb begin
    w_want = DIR_STOP;
    if (int'(w_mag) > THRESH) w_want = (i_diff > 13'sd0) ? DIR_CCW : DIR_CW;
  end

  always_comb begin
    w_man_want = DIR_STOP;
    if (i_man_btn0 && !i_man_btn1) w_man_want = DIR_CW;
    if (i_man_btn1 && !i_man_btn0) w_man_want = DIR_CCW;
  end

  assign w_dec     = limit_gate(w_want, i_pos, 32'(POS_MIN), 32'(POS_MAX));
  assign w_man_dir = limit_gate(w_man_want, i_pos, 32'(POS_MIN), 32'(POS_MAX));
  // While moving r_dir is never STOP, so a STOP result here means a limit was reached.
  assign w_lim_hit = r_active &&
                     (limit_gate(r_dir, i_pos, 32'(POS_MIN), 32'(POS_MAX)) == DIR_STOP);

  assign o_skip        = i_align && !r_active && (w_dec == DIR_STOP);
  assign o_move_done   = i_align && r_active &&
                         ((r_cnt == 32'(MOVE_CYCLES - 1)) || w_lim_hit);
  assign o_settle_done = i_settle && (r_cnt == 32'(SETTLE_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_abort) begin
      r_active <= 1'b0;
      r_dir    <= DIR_STOP;
      r_cnt    <= '0;
    end else if (i_manual) begin
      r_active <= 1'b0;
      r_dir    <= w_man_dir;
      r_cnt    <= '0;
    end else if (i_align && !r_active) begin
      r_active <= (w_dec != DIR_STOP);
      r_dir    <= w_dec;
      r_cnt    <= '0;
    end else if (i_align) begin
      if (o_move_done) begin
        r_active <= 1'b0;
        r_dir    <= DIR_STOP;
        r_cnt    <= '0;
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
    end else if (i_settle) begin
      r_cnt <= r_cnt + 32'd1;
    end else begin
      r_active <= 1'b0;
      r_dir    <= DIR_STOP;
      r_cnt    <= '0;
    end
  end

  assign o_btn0 = r_dir[0];
  assign o_btn1 = r_dir[1];
  assign o_es   = r_active;

endmodule

// File: rtl/tracker_sequencer.sv
// Solar tracker sequencer: periodic LDR sampling, horizontal then vertical
// alignment moves with settle time, and a manual jog override.
module tracker_sequencer
  import tracker_sequencer_pkg::*;
#(
  parameter int THRESH        = 64,
  parameter int MOVE_CYCLES   = 1000,
  parameter int SETTLE_CYCLES = 500,
  parameter int PERIOD_CYCLES = 2000,
  parameter int POS_MIN       = POS_MIN_DEF,
  parameter int POS_MAX       = POS_MAX_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mode_manual,
  input  logic        i_btn_l,
  input  logic        i_btn_r,
  input  logic        i_btn_u,
  input  logic        i_btn_d,
  input  logic        i_ldr_valid,
  input  logic [11:0] i_ldr_l,
  input  logic [11:0] i_ldr_r,
  input  logic [11:0] i_ldr_t,
  input  logic [11:0] i_ldr_b,
  input  logic [31:0] i_pos_h,
  input  logic [31:0] i_pos_v,
  output logic        o_h_btn0,
  output logic        o_h_btn1,
  output logic        o_v_btn0,
  output logic        o_v_btn1,
  output logic        o_es_h,
  output logic        o_es_v,
  output logic        o_mc,
  output logic        o_busy,
  output logic [2:0]  o_state
);

  state_t             r_state;
  state_t             w_next;
  logic [31:0]        r_idle_cnt;
  logic [11:0]        r_ldr_l, r_ldr_r, r_ldr_t, r_ldr_b;
  logic               r_mc;
  logic               r_busy;
  logic signed [12:0] w_dh, w_dv;
  logic               w_abort, w_manual;
  logic               w_h_skip, w_h_move_done, w_h_settle_done;
  logic               w_v_skip, w_v_move_done, w_v_settle_done;

  assign w_dh     = $signed({1'b0, r_ldr_l}) - $signed({1'b0, r_ldr_r});
  assign w_dv     = $signed({1'b0, r_ldr_t}) - $signed({1'b0, r_ldr_b});
  assign w_abort  = i_mode_manual && (r_state != ST_MANUAL);
  assign w_manual = i_mode_manual && (r_state == ST_MANUAL);

  always_comb begin
    w_next = r_state;
    if (i_mode_manual) begin
      w_next = ST_MANUAL;
    end else begin
      case (r_state)
        ST_IDLE:     if (r_idle_cnt == 32'(PERIOD_CYCLES - 1)) w_next = ST_SAMPLE;
        ST_SAMPLE:   if (i_ldr_valid) w_next = ST_ALIGN_H;
        ST_ALIGN_H:  if (w_h_skip) w_next = ST_ALIGN_V;
                     else if (w_h_move_done) w_next = ST_SETTLE_H;
        ST_SETTLE_H: if (w_h_settle_done) w_next = ST_ALIGN_V;
        ST_ALIGN_V:  if (w_v_skip) w_next = ST_IDLE;
                     else if (w_v_move_done) w_next = ST_SETTLE_V;
        ST_SETTLE_V: if (w_v_settle_done) w_next = ST_IDLE;
        ST_MANUAL:   w_next = ST_IDLE;
        default:     w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_idle_cnt <= '0;
      r_ldr_l    <= '0;
      r_ldr_r    <= '0;
      r_ldr_t    <= '0;
      r_ldr_b    <= '0;
      r_mc       <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_next;
      // Idle period restarts from zero on every entry into IDLE.
      r_idle_cnt <= ((r_state == ST_IDLE) && (w_next == ST_IDLE)) ?
                    r_idle_cnt + 32'd1 : '0;
      if ((r_state == ST_SAMPLE) && (w_next == ST_ALIGN_H)) begin
        r_ldr_l <= i_ldr_l;
        r_ldr_r <= i_ldr_r;
        r_ldr_t <= i_ldr_t;
        r_ldr_b <= i_ldr_b;
      end
      r_mc   <= (w_next == ST_MANUAL);
      r_busy <= (w_next != ST_IDLE);
    end
  end

  axis_mover #(
    .THRESH(THRESH), .MOVE_CYCLES(MOVE_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES),
    .POS_MIN(POS_MIN), .POS_MAX(POS_MAX)
  ) u_axis_h (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_align(r_state == ST_ALIGN_H), .i_settle(r_state == ST_SETTLE_H),
    .i_manual(w_manual), .i_abort(w_abort),
    .i_diff(w_dh), .i_pos(i_pos_h),
    .i_man_btn0(i_btn_r), .i_man_btn1(i_btn_l),
    .o_btn0(o_h_btn0), .o_btn1(o_h_btn1), .o_es(o_es_h),
    .o_skip(w_h_skip), .o_move_done(w_h_move_done), .o_settle_done(w_h_settle_done)
  );

  axis_mover #(
    .THRESH(THRESH), .MOVE_CYCLES(MOVE_CYCLES), .SETTLE_CYCLES(SETTLE_CYCLES),
    .POS_MIN(POS_MIN), .POS_MAX(POS_MAX)
  ) u_axis_v (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_align(r_state == ST_ALIGN_V), .i_settle(r_state == ST_SETTLE_V),
    .i_manual(w_manual), .i_abort(w_abort),
    .i_diff(w_dv), .i_pos(i_pos_v),
    .i_man_btn0(i_btn_u), .i_man_btn1(i_btn_d),
    .o_btn0(o_v_btn0), .o_btn1(o_v_btn1), .o_es(o_es_v),
    .o_skip(w_v_skip), .o_move_done(w_v_move_done), .o_settle_done(w_v_settle_done)
  );

  assign o_state = r_state;
  assign o_busy  = r_busy;
  assign o_mc    = r_mc;

endmodule

// File: tb/tb_tracker_sequencer.sv
// Directed-vector bench for tracker_sequencer with default parameters.
module tb_tracker_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, mode_manual, btn_l, btn_r, btn_u, btn_d, ldr_valid;
  logic [11:0] ldr_l, ldr_r, ldr_t, ldr_b;
  logic [31:0] pos_h, pos_v;
  logic        h_btn0, h_btn1, v_btn0, v_btn1, es_h, es_v, mc, busy;
  logic [2:0]  state;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  tracker_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_mode_manual(mode_manual),
    .i_btn_l(btn_l), .i_btn_r(btn_r), .i_btn_u(btn_u), .i_btn_d(btn_d),
    .i_ldr_valid(ldr_valid), .i_ldr_l(ldr_l), .i_ldr_r(ldr_r),
    .i_ldr_t(ldr_t), .i_ldr_b(ldr_b), .i_pos_h(pos_h), .i_pos_v(pos_v),
    .o_h_btn0(h_btn0), .o_h_btn1(h_btn1), .o_v_btn0(v_btn0), .o_v_btn1(v_btn1),
    .o_es_h(es_h), .o_es_v(es_v), .o_mc(mc), .o_busy(busy), .o_state(state)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ldr(input int l, input int r, input int t, input int b);
    ldr_l = 12'(l); ldr_r = 12'(r); ldr_t = 12'(t); ldr_b = 12'(b);
  endtask

  task automatic wait_sample();
    int n;
    n = 0;
    while (state !== 3'd1 && n < 5000) begin step(); n++; end
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL wait_sample: state=%0d required=1", state); end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    step(); step();
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
    checks++;
    if ({h_btn0, h_btn1, v_btn0, v_btn1, es_h, es_v, mc, busy} !== 8'h00) begin
      errors++; $display("FAIL reset_outputs: got %b want 00000000",
                         {h_btn0, h_btn1, v_btn0, v_btn1, es_h, es_v, mc, busy});
    end
    rst_n = 1'b1;
    n = 0;
    while (state !== 3'd1 && n < 3000) begin
      if (n == 10) begin set_ldr(3000, 0, 0, 0); ldr_valid = 1'b1; end
      step();
      ldr_valid = 1'b0;
      n++;
    end
    checks++;
    if (n !== 2000) begin errors++; $display("FAIL idle_period: got %0d cycles want 2000", n); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL sample_busy: got %b want 1", busy); end
  endtask

  task automatic test_align_h();
    int n, m;
    set_ldr(2000, 1000, 800, 800);
    pos_h = 32'd1500; pos_v = 32'd1500;
    ldr_valid = 1'b1;
    step();
    ldr_valid = 1'b0;
    checks++;
    if (state !== 3'd2 || h_btn1 !== 1'b0) begin
      errors++; $display("FAIL align_h_entry: state=%0d btn1=%b want 2/0", state, h_btn1);
    end
    step();
    n = 0;
    while (h_btn1 === 1'b1 && h_btn0 === 1'b0 && es_h === 1'b1 && n < 2000) begin step(); n++; end
    checks++;
    if (n !== 1000) begin errors++; $display("FAIL move_len_h: got %0d want 1000", n); end
    checks++;
    if (state !== 3'd3 || {h_btn0, h_btn1, es_h} !== 3'b000) begin
      errors++; $display("FAIL settle_h_entry: state=%0d btn/es=%b want 3/000", state, {h_btn0, h_btn1, es_h});
    end
    m = 0;
    while (state === 3'd3 && m < 1000) begin step(); m++; end
    checks++;
    if (m !== 500 || state !== 3'd4) begin
      errors++; $display("FAIL settle_len_h: got %0d state=%0d want 500/4", m, state);
    end
    step();
    checks++;
    if (state !== 3'd0 || busy !== 1'b0 || v_btn0 !== 1'b0 || v_btn1 !== 1'b0) begin
      errors++; $display("FAIL v_skip_idle: state=%0d busy=%b want 0/0", state, busy);
    end
  endtask

  task automatic test_no_move();
    wait_sample();
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL sample_wait: got %0d want 1", state); end
    set_ldr(1030, 1000, 800, 800);
    ldr_valid = 1'b1;
    step();
    ldr_valid = 1'b0;
    checks++;
    if (state !== 3'd2 || {h_btn0, h_btn1, v_btn0, v_btn1} !== 4'b0) begin
      errors++; $display("FAIL nomove_h: state=%0d btns=%b want 2/0000", state, {h_btn0, h_btn1, v_btn0, v_btn1});
    end
    step();
    checks++;
    if (state !== 3'd4 || {h_btn0, h_btn1, v_btn0, v_btn1} !== 4'b0) begin
      errors++; $display("FAIL nomove_v: state=%0d btns=%b want 4/0000", state, {h_btn0, h_btn1, v_btn0, v_btn1});
    end
    step();
    checks++;
    if (state !== 3'd0 || {h_btn0, h_btn1, v_btn0, v_btn1} !== 4'b0) begin
      errors++; $display("FAIL nomove_idle: state=%0d btns=%b want 0/0000", state, {h_btn0, h_btn1, v_btn0, v_btn1});
    end
  endtask

  task automatic test_thresh_manual();
    wait_sample();
    set_ldr(1064, 1000, 865, 800);
    pos_h = 32'd2500; pos_v = 32'd1500;
    ldr_valid = 1'b1;
    step();
    ldr_valid = 1'b0;
    step();
    checks++;
    if (state !== 3'd4 || {h_btn0, h_btn1} !== 2'b00) begin
      errors++; $display("FAIL thresh_eq_skip: state=%0d hbtn=%b want 4/00", state, {h_btn0, h_btn1});
    end
    step();
    checks++;
    if ({v_btn0, v_btn1, es_v, es_h} !== 4'b0110) begin
      errors++; $display("FAIL thresh_over_move: v0,v1,esv,esh=%b want 0110", {v_btn0, v_btn1, es_v, es_h});
    end
    for (int i = 0; i < 199; i++) step();
    checks++;
    if (v_btn1 !== 1'b1) begin errors++; $display("FAIL v_move_200: got %b want 1", v_btn1); end
    mode_manual = 1'b1; btn_u = 1'b1; btn_d = 1'b1;
    step();
    checks++;
    if (state !== 3'd6 || mc !== 1'b1 || {v_btn0, v_btn1, es_v} !== 3'b000) begin
      errors++; $display("FAIL manual_entry: state=%0d mc=%b v/es=%b want 6/1/000", state, mc, {v_btn0, v_btn1, es_v});
    end
    step();
    checks++;
    if ({v_btn0, v_btn1} !== 2'b00) begin errors++; $display("FAIL manual_both: got %b want 00", {v_btn0, v_btn1}); end
    btn_u = 1'b0;
    step();
    checks++;
    if ({v_btn0, v_btn1, es_v} !== 3'b010) begin
      errors++; $display("FAIL manual_down: got %b want 010", {v_btn0, v_btn1, es_v});
    end
    btn_d = 1'b0; btn_r = 1'b1;
    step();
    checks++;
    if ({h_btn0, h_btn1, v_btn1} !== 3'b000) begin
      errors++; $display("FAIL manual_cw_gate: got %b want 000", {h_btn0, h_btn1, v_btn1});
    end
    btn_r = 1'b0; btn_l = 1'b1;
    step();
    checks++;
    if ({h_btn0, h_btn1, es_h} !== 3'b010) begin
      errors++; $display("FAIL manual_left: got %b want 010", {h_btn0, h_btn1, es_h});
    end
    mode_manual = 1'b0;
    step();
    btn_l = 1'b0;
    checks++;
    if (state !== 3'd0 || mc !== 1'b0 || {h_btn0, h_btn1, v_btn0, v_btn1} !== 4'b0) begin
      errors++; $display("FAIL manual_exit: state=%0d mc=%b btns=%b want 0/0/0000", state, mc, {h_btn0, h_btn1, v_btn0, v_btn1});
    end
  endtask

  task automatic test_cw_gate();
    int seen;
    wait_sample();
    set_ldr(1000, 1500, 800, 800);
    pos_h = 32'd2500;
    ldr_valid = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      ldr_valid = 1'b0;
      if (h_btn0 !== 1'b0 || es_h !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL cw_gate: btn0 high %0d cycles want 0", seen); end
    checks++;
    if (state !== 3'd0) begin errors++; $display("FAIL cw_gate_idle: got %0d want 0", state); end
  endtask

  task automatic test_limit_abort();
    wait_sample();
    set_ldr(1000, 1500, 800, 800);
    pos_h = 32'd2400;
    ldr_valid = 1'b1;
    step();
    ldr_valid = 1'b0;
    step();
    for (int i = 0; i < 299; i++) step();
    pos_h = 32'd2500;
    checks++;
    if (h_btn0 !== 1'b1 || es_h !== 1'b1) begin
      errors++; $display("FAIL abort_pre: btn0=%b es=%b want 1/1", h_btn0, es_h);
    end
    step();
    checks++;
    if (h_btn0 !== 1'b0 || es_h !== 1'b0 || state !== 3'd3) begin
      errors++; $display("FAIL abort_drop: btn0=%b es=%b state=%0d want 0/0/3", h_btn0, es_h, state);
    end
    pos_h = 32'd1500;
  endtask

  task automatic test_reset_mid_v();
    int n;
    wait_sample();
    set_ldr(1000, 1000, 800, 1300);
    pos_v = 32'd1500;
    ldr_valid = 1'b1;
    step();
    ldr_valid = 1'b0;
    step(); step();
    for (int i = 0; i < 50; i++) step();
    checks++;
    if (state !== 3'd4 || v_btn0 !== 1'b1) begin
      errors++; $display("FAIL v_cw_move: state=%0d v_btn0=%b want 4/1", state, v_btn0);
    end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    checks++;
    if (state !== 3'd0 || {h_btn0, h_btn1, v_btn0, v_btn1, es_h, es_v, mc, busy} !== 8'h00) begin
      errors++; $display("FAIL reset_mid: state=%0d outs=%b want 0/00000000", state,
                         {h_btn0, h_btn1, v_btn0, v_btn1, es_h, es_v, mc, busy});
    end
    n = 0;
    while (state !== 3'd1 && n < 3000) begin step(); n++; end
    checks++;
    if (n !== 2000) begin errors++; $display("FAIL reset_mid_period: got %0d want 2000", n); end
  endtask

  initial begin
    rst_n = 1'b0; mode_manual = 1'b0; ldr_valid = 1'b0;
    btn_l = 1'b0; btn_r = 1'b0; btn_u = 1'b0; btn_d = 1'b0;
    set_ldr(0, 0, 0, 0);
    pos_h = 32'd1500; pos_v = 32'd1500;
    test_reset();
    test_align_h();
    test_no_move();
    test_thresh_manual();
    test_cw_gate();
    test_limit_abort();
    test_reset_mid_v();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
